// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access sizes, FSM states
// and the wait-state limit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LATENCY_MAX = 15;
  localparam int CW          = $clog2(LATENCY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } stateT;

  // Byte lanes touched by an access; encoding 2'b11 behaves as a word.
  function automatic logic [3:0] laneMask(input logic [1:0] size);
    case (size)
      SZ_BYTE: laneMask = 4'b0001;
      SZ_HALF: laneMask = 4'b0011;
      default: laneMask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load lane extraction: keeps the low byte/half/word of the gathered bytes and
// sign- or zero-extends it to 32 bits.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] rawWord,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  output logic [31:0] loadData
);

  // NOTE: assign every combinational output a default first so no path leaves it unassigned (latch).
  always_comb begin
    loadData = rawWord;
    case (size)
      SZ_BYTE: loadData = {{24{~unsignedLoad & rawWord[7]}}, rawWord[7:0]};
      SZ_HALF: loadData = {{16{~unsignedLoad & rawWord[15]}}, rawWord[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with fixed wait states, little-endian lanes and
// wrap-around addressing. Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);

  stateT         state, stateNext;
  logic [CW-1:0] count, countNext;

  logic          weQ;
  logic [1:0]    sizeQ;
  logic          unsignedQ;
  logic [AW-1:0] addrQ;
  logic [31:0]   wdataQ;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] byteIdx [4];
  logic [31:0]   rawWord;
  logic [31:0]   loadData;
  logic [3:0]    laneEn;
  logic          misaligned;
  logic          xfer;
  logic          memWrite;
  logic          doneQ;
  logic [31:0]   rdataQ;

  // Addresses alias modulo DEPTH, so bits above the index are intentionally ignored.
  logic unusedAddrHi;
  assign unusedAddrHi = ^addr_i[31:AW];

  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (LATENCY == 0) begin
            stateNext = XFER;
          end else begin
            stateNext = WAIT;
            countNext = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (count == '0) stateNext = XFER;
        else             countNext = count - 1'b1;
      end
      XFER:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      weQ       <= 1'b0;
      sizeQ     <= SZ_BYTE;
      unsignedQ <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
    end else if (state == IDLE && req_i) begin
      weQ       <= we_i;
      sizeQ     <= size_i;
      unsignedQ <= unsigned_i;
      addrQ     <= addr_i[AW-1:0];
      wdataQ    <= wdata_i;
    end
  end

  // Each lane indexes addr+k; the AW-bit add wraps the index around DEPTH.
  always_comb begin
    rawWord = '0;
    for (int k = 0; k < 4; k++) begin
      byteIdx[k]          = addrQ + AW'(k);
      rawWord[8*k +: 8]   = mem[byteIdx[k]];
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = ((sizeQ == SZ_HALF) && addrQ[0]) ||
                      (sizeQ[1] && (addrQ[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign xfer     = (state == XFER);
  assign laneEn   = laneMask(sizeQ);
  assign memWrite = xfer & weQ & ~misaligned;

  // NOTE: the storage array is deliberately left out of reset; reset only clears control state.
  always_ff @(posedge clk_i) begin
    if (memWrite) begin
      for (int k = 0; k < 4; k++) begin
        if (laneEn[k]) mem[byteIdx[k]] <= wdataQ[8*k +: 8];
      end
    end
  end

  dmem_lane_align uLaneAlign (
    .rawWord      (rawWord),
    .size         (sizeQ),
    .unsignedLoad (unsignedQ),
    .loadData     (loadData)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      doneQ  <= 1'b0;
      rdataQ <= '0;
    end else begin
      doneQ <= xfer;
      if (xfer && !weQ) rdataQ <= misaligned ? '0 : loadData;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic errQ;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) errQ <= 1'b0;
    else        errQ <= xfer & misaligned;
  end
  assign err_o = errQ;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o  = (state != IDLE);
  assign done_o  = doneQ;
  assign rdata_o = rdataQ;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, 1024, byte capacity; power of two, >= 8.
REQ-002 SHALL provide parameter LATENCY, 2, wait states per access, range 0..15.
REQ-003 SHALL provide ports:
clk_i  in  1  single clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
req_i  in  1  access request
we_i  in  1  1 = store, 0 = load
size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
addr_i  in  32  byte address
wdata_i  in  32  store data, little-endian lanes from bit 0
busy_o  out  1  access in progress; requests ignored
done_o  out  1  one-cycle completion pulse, load or store
rdata_o  out  32  load result, valid with done_o
err_o  out  1  misaligned-access flag, valid with done_o

Function
REQ-004 SHALL use FSM IDLE, WAIT, XFER; busy_o = (state != IDLE).
REQ-005 SHALL sample req_i only in IDLE; at accept edge E, latch we_i, size_i, unsigned_i, addr_i, wdata_i; next state WAIT with counter = LATENCY-1, or XFER if LATENCY = 0.
REQ-006 SHALL decrement the counter each WAIT cycle and go to XFER when it is 0.
REQ-007 SHALL perform the memory operation at the XFER edge (E+LATENCY+1), return to IDLE, and drive done_o high for exactly the following cycle.
REQ-008 SHALL accept a new req_i during the done_o cycle (back-to-back period LATENCY+2 cycles); requests while busy_o=1 are dropped, not queued.
REQ-009 SHALL store bytes little-endian: byte at addr, half at addr..addr+1, word at addr..addr+3; other bytes unchanged.
REQ-010 SHALL form every byte index as (addr + k) mod DEPTH; addresses beyond DEPTH alias and wrap, never fault.
REQ-011 SHALL extend loaded byte or half to 32 bits per unsigned_i; word loads are unmodified.
REQ-012 SHALL update rdata_o only on load completion; stores and idle cycles hold its previous value.
REQ-013 SHALL give a load that follows a store to the same address the stored data, with no bypass hazard.

Reset
REQ-014 SHALL on rst_i low, immediately: state IDLE, counter 0, busy_o 0, done_o 0, rdata_o 0, err_o 0.
REQ-015 SHALL abort an in-flight access on reset, with no write commit and no done_o; memory contents are not reset.

Configuration
REQ-016 SHALL, with DMEM_ALIGN_CHECK_EN defined, treat half at odd addr or word with addr[1:0] != 0 as misaligned: no memory write, rdata_o forced 0, err_o 1 with done_o, and timing unchanged.
REQ-017 SHALL, without DMEM_ALIGN_CHECK_EN, tie err_o to 0 and execute misaligned accesses on consecutive bytes per REQ-010.

Structure
REQ-018 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum and LATENCY_MAX = 15 in package dmem_pkg.
REQ-019 SHALL implement lane extract and extension in combinational sub-module dmem_lane_align.

Verification
REQ-020 Reset then word store 0xDEADBEEF @0x10, LATENCY=2 -> busy_o 3 cycles, done_o 1 cycle; word load @0x10 -> rdata_o 0xDEADBEEF.
REQ-021 Byte loads @0x10..0x13 signed -> 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE; half load @0x12 unsigned -> 0x0000DEAD.
REQ-022 Byte store 0x55 @0x11 over 0xDEADBEEF -> word load gives 0xDEAD55EF; req_i pulsed during busy_o -> ignored, no extra done_o.
REQ-023 DEPTH=1024, word store 0x11223344 @0x3FE, no align check -> byte 0x3FF = 0x33, byte 0x000 = 0x22; load @0x400 aliases @0x000.
REQ-024 DMEM_ALIGN_CHECK_EN, word store @0x21 -> err_o 1 with done_o, memory unchanged; reset asserted in WAIT of a store -> no write, done_o never pulses.
